// File: rtl/mem_access_unit_pkg.sv
// Shared widths, access-size encodings, FSM states and the latched request record.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mem_access_unit_pkg;

    localparam int ADDR_SIZE   = 32;
    localparam int WORD_SIZE_B = 4;
    localparam int W           = 8 * WORD_SIZE_B;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Request fields that must survive past the accept cycle.
    typedef struct packed {
        logic         we;
        logic [1:0]   size;
        logic         is_unsigned;
        logic [W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_access_unit_data_align.sv
// Load extraction/extension and sub-word store merge on a little-endian word.
// Latency: purely combinational.
// Backpressure: none, the caller decides when results are used.
module mem_data_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]   size,
    input  logic         is_unsigned,
    input  logic [W-1:0] word,
    input  logic [W-1:0] new_data,
    output logic [W-1:0] load_data,
    output logic [W-1:0] store_word
);

    // The addressed byte always sits in word[7:0], so sub-word fields are the low bits.
    always_comb begin
        load_data  = word;
        store_word = new_data;
        case (size)
            SIZE_BYTE: begin
                load_data  = {{(W-8){~is_unsigned & word[7]}}, word[7:0]};
                store_word = {word[W-1:8], new_data[7:0]};
            end
            SIZE_HALF: begin
                load_data  = {{(W-16){~is_unsigned & word[15]}}, word[15:0]};
                store_word = {word[W-1:16], new_data[15:0]};
            end
            default: begin
                load_data  = word;
                store_word = new_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Bus initiator turning core loads/stores into Cs/We/Addr/Wdata/Ack transactions; sub-word stores are read-modify-write.
// Latency: load or word store responds 3 cycles after accept with a 2-cycle ack; sub-word store 6 cycles.
// Backpressure: Req_ready is high only in IDLE; the bus stalls on Ack, bounded by TIMEOUT cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req_valid,
    output logic                 Req_ready,
    input  logic                 Req_we,
    input  logic [1:0]           Req_size,
    input  logic                 Req_unsigned,
    input  logic [ADDR_SIZE-1:0] Req_addr,
    input  logic [W-1:0]         Req_wdata,
    output logic                 Resp_valid,
    output logic [W-1:0]         Resp_rdata,
    output logic                 Resp_err,
    output logic [ADDR_SIZE-1:0] Addr,
    output logic                 Cs,
    output logic                 We,
    output logic [W-1:0]         Wdata,
    input  logic [W-1:0]         Rdata,
    input  logic                 Ack
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    req_t             req;
    logic [CNT_W-1:0] tcnt;
    logic             expired;
    logic [W-1:0]     load_data;
    logic [W-1:0]     store_word;

    assign Req_ready = (state == ST_IDLE);

    // tcnt holds the number of Cs-high cycles already spent, so the last allowed one is TIMEOUT-1.
    assign expired = (TIMEOUT != 0) && (tcnt == CNT_LAST);

    // Rdata feeds the aligner directly; its results are only registered on the Ack edge.
    mem_data_align u_align (
        .size        (req.size),
        .is_unsigned (req.is_unsigned),
        .word        (Rdata),
        .new_data    (req.wdata),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // Control FSM, timeout counter and all registered bus/response outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_IDLE;
            req        <= '0;
            tcnt       <= '0;
            Cs         <= 1'b0;
            We         <= 1'b0;
            Addr       <= '0;
            Wdata      <= '0;
            Resp_valid <= 1'b0;
            Resp_err   <= 1'b0;
            Resp_rdata <= '0;
        end else begin
            Resp_valid <= 1'b0;
            Resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req_valid) begin
                        req.we          <= Req_we;
                        req.size        <= Req_size;
                        req.is_unsigned <= Req_unsigned;
                        req.wdata       <= Req_wdata;
                        tcnt            <= '0;
                        if (Req_size == SIZE_ILLEGAL) begin
                            // Rejected without touching the bus.
                            Resp_valid <= 1'b1;
                            Resp_err   <= 1'b1;
                            Resp_rdata <= '0;
                            state      <= ST_DONE;
                        end else if (Req_we && Req_size == SIZE_WORD) begin
                            Cs    <= 1'b1;
                            We    <= 1'b1;
                            Addr  <= Req_addr;
                            Wdata <= Req_wdata;
                            state <= ST_WR;
                        end else begin
                            Cs    <= 1'b1;
                            We    <= 1'b0;
                            Addr  <= Req_addr;
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (Ack) begin
                        Cs   <= 1'b0;
                        tcnt <= '0;
                        if (req.we) begin
                            Wdata <= store_word;
                            state <= ST_GAP;
                        end else begin
                            Resp_valid <= 1'b1;
                            Resp_rdata <= load_data;
                            state      <= ST_DONE;
                        end
                    end else if (expired) begin
                        // Abort; a pending sub-word store never reaches its write.
                        Cs         <= 1'b0;
                        Resp_valid <= 1'b1;
                        Resp_err   <= 1'b1;
                        Resp_rdata <= '0;
                        state      <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    Cs    <= 1'b1;
                    We    <= 1'b1;
                    tcnt  <= '0;
                    state <= ST_WR;
                end
                ST_WR: begin
                    if (Ack || expired) begin
                        Cs         <= 1'b0;
                        We         <= 1'b0;
                        Resp_valid <= 1'b1;
                        Resp_err   <= ~Ack;
                        Resp_rdata <= '0;
                        state      <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    Cs    <= 1'b0;
                    We    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Bus initiator that turns core load/store requests into transactions on the Cs/We/Addr/Wdata/Rdata/Ack memory bus served by the RAM.
- Accepts byte, halfword and word accesses. Performs sign or zero extension on loads.
- The RAM writes only whole words, so sub-word stores are done as read-modify-write.
- Sits between the core's memory stage and the RAM or bus decoder.

Parameters:
- TIMEOUT, 16: bus cycles to wait for Ack before aborting the access with an error; 0 disables the timeout.
- Widths come from defines.vh: `ADDR_SIZE` and `WORD_SIZE_B`. Data width W = 8*`WORD_SIZE_B`.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous, active-high reset
- Req_valid  in  1  core request present
- Req_ready  out  1  unit idle; the request is accepted when Req_valid & Req_ready
- Req_we  in  1  1 = store, 0 = load
- Req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- Req_unsigned  in  1  zero-extend a load (ignored for stores and word loads)
- Req_addr  in  `ADDR_SIZE  byte address; any alignment
- Req_wdata  in  W  store data, right-aligned
- Resp_valid  out  1  one-cycle completion pulse
- Resp_rdata  out  W  extended load data; 0 for stores and errors
- Resp_err  out  1  qualifies Resp_valid: timeout or illegal size
- Addr  out  `ADDR_SIZE  bus address
- Cs  out  1  bus select
- We  out  1  bus write
- Wdata  out  W  bus write data
- Rdata  in  W  bus read data
- Ack  in  1  bus acknowledge

Behaviour:
- Reset (async, immediate):
  - State returns to IDLE.
  - Cs, We, Resp_valid and Resp_err go to 0. Addr, Wdata and Resp_rdata go to 0.
  - Req_ready goes to 1 after reset deasserts.
  - Reset during a transaction abandons it and drops Cs at once. No response is produced.
- Bus rules:
  - All bus outputs are registered.
  - Cs, Addr, We and Wdata are held stable from assertion until Ack is sampled high.
  - Cs deasserts on the edge that samples Ack, so there is always at least one Cs-low cycle between transactions.
  - Rdata is captured on that same edge.
  - Ack sampled while Cs is low is ignored.
  - Data is little-endian: the byte at Addr is Rdata[7:0].
- States: IDLE, RD, GAP, WR, DONE.
- IDLE:
  - Req_ready = 1.
  - On accept, latch the request. Next state:
    - RD if it is a load or a sub-word store.
    - WR if it is a word store.
    - DONE with error if Req_size = 11; no bus activity occurs.
- RD:
  - Cs = 1, We = 0.
  - On Ack, capture Rdata.
  - A load goes to DONE. A store merges Req_wdata into the low byte(s) of the captured word and goes to GAP.
- GAP: Cs = 0 for one cycle, then WR.
- WR:
  - Cs = 1, We = 1, Wdata = the full word or the merged word.
  - On Ack, go to DONE.
- DONE:
  - Resp_valid = 1 for one cycle, with Resp_rdata and Resp_err.
  - Next state is IDLE. Req_ready = 0 in this cycle.
- Load extension: byte → bit 7 (signed) or zeros; half → bit 15 (signed) or zeros; word passes through unchanged.
- Latency (request accepted in cycle T):
  - Load or word store: Cs high T+1..T+2, Ack in T+2, Resp_valid in T+3.
  - Sub-word store: read T+1..T+2, GAP T+3, write T+4..T+5, Resp_valid T+6.
- Timeout:
  - A counter runs in RD and WR and clears whenever Cs is asserted.
  - If Ack has not arrived after TIMEOUT cycles with Cs high, drop Cs and go to DONE with Resp_err = 1 and Resp_rdata = 0.
  - A sub-word store that times out in RD performs no write.
  - If Ack arrives in the same cycle the timeout expires, Ack wins.
- Address wrap: the bus address is presented unmodified, and RAM range handling belongs to the RAM.

Decomposition:
- Add to defines.vh: `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD` (2-bit encodings) and the state encodings for this block.
- Sub-module mem_data_align (combinational), which handles:
  - load extraction and extension (size, unsigned) from the captured word;
  - the store merge (size, old word, new data).
- The FSM, timeout counter and bus registers stay in mem_access_unit.

Test Plan:
- Word store then word load:
  - Store 0xDEADBEEF at 0x10 → one bus write, Resp_valid at T+3.
  - Load from 0x10 → Resp_rdata = 0xDEADBEEF, Resp_valid at T+3, Resp_err = 0.
- Byte load with sign handling:
  - Memory at 0x20 holds 0x000000F5.
  - Signed byte load → 0xFFFFFFF5. Unsigned byte load → 0x000000F5.
  - Signed halfword load from 0x20 → 0x000000F5.
- Sub-word store read-modify-write:
  - Memory at 0x30 holds 0x11223344. Store halfword 0xAAAA.
  - Bus trace must be: read, one Cs-low GAP cycle, write of 0x1122AAAA. Resp_valid at T+6.
  - A following word load returns 0x1122AAAA.
- Unaligned word access: store 0xCAFEBABE at 0x13, then load from 0x13 → 0xCAFEBABE.
- Timeout, with a bus model that never acks:
  - Load → Cs drops after 16 cycles; Resp_valid = 1, Resp_err = 1, Resp_rdata = 0.
  - Illegal size 11 → Resp_err = 1 with no Cs activity.
- Reset mid-transaction and back-to-back requests:
  - Assert Rst while in WR → Cs drops asynchronously, no Resp_valid, Req_ready = 1 after release.
  - Two back-to-back requests → the second is accepted only in the cycle after DONE, and Cs is low for at least one cycle between the two transactions.
